pill_count_display: RTL and testbench
=====================================

Name: pill_count_display

Overview:
- Downstream stage of the pill-bottling controller. Consumes its `bottle_count`, `pill_count`, `working_state` and `alarm_state` outputs and drives a 6-digit multiplexed 7-segment display.
- Converts both 8-bit binary counts to 3-digit BCD with a sequential double-dabble engine.
- Scans the digits with leading-zero blanking, shows the working indicator on a decimal point, and blinks the whole display while the alarm is raised.

Parameters:
- SCAN_DIV, 1000: clk cycles each digit is held before the scan advances; minimum 1.
- BLINK_DIV, 250000: clk cycles per blink half-period while the alarm is active; minimum 1.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset; one clock, asynchronous active-low reset.
- bottle_count  input  8  filled-bottle count from the bottling controller, binary 0..255.
- pill_count  input  8  current pill count from the bottling controller, binary 0..255.
- working_state  input  1  controller is in its working state.
- alarm_state  input  1  controller alarm.
- bottle_bcd  output  12  registered BCD of the bottle snapshot, {hundreds, tens, ones}.
- pill_bcd  output  12  registered BCD of the pill snapshot, {hundreds, tens, ones}.
- seg  output  8  segment drive, active-high; [6:0] = g..a, [7] = dp.
- dig_sel  output  6  digit enables, active-low, at most one bit low.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - bottle_bcd=0, pill_bcd=0, seg=8'h00, dig_sel=6'b111111.
  - Converter FSM=IDLE, scan counter=0, digit index=0, blink counter=0, blink phase=ON.
  - Reset asserted mid-conversion discards the conversion; the first conversion starts in the first cycle after release.
- Converter FSM, free-running with a 10-cycle period:
  - IDLE (1 cycle): snapshot bottle_count and pill_count into shift registers, clear the BCD accumulators and the shift count, go to SHIFT.
  - SHIFT (8 cycles): in each cycle, every BCD nibble >=5 first gets +3, then the {BCD, binary} pair shifts left by 1. Both counts convert in parallel. After the 8th shift, go to LOAD.
  - LOAD (1 cycle): copy both accumulators to bottle_bcd and pill_bcd together in the same cycle, go to IDLE.
  - Inputs that change during SHIFT or LOAD are ignored until the next IDLE.
  - Worst-case latency from an input change to the new bottle_bcd/pill_bcd value is 20 cycles.
  - Width rules: 8-bit binary gives 3 nibbles; the hundreds nibble is at most 2. 255 converts to 0x255.
- Scan:
  - The scan counter counts 0..SCAN_DIV-1 and wraps.
  - On wrap, the digit index advances 0..5 and then back to 0. With SCAN_DIV=1 the index advances every cycle.
  - Digit mapping: 0=pill ones, 1=pill tens, 2=pill hundreds, 3=bottle ones, 4=bottle tens, 5=bottle hundreds. dig_sel bit i is low for index i.
  - seg and dig_sel are registered and lag the digit index by 1 cycle.
- Leading-zero blanking, applied per group:
  - Hundreds digit is blank (seg[6:0]=0) when it is 0.
  - Tens digit is blank when both hundreds and tens are 0.
  - Ones digit is always shown.
  - A blanked digit still asserts its dig_sel bit.
- Segment patterns: standard pattern for 0..9; nibbles 10..15 cannot occur and display as blank.
- Decimal point: seg[7]=1 only while index 3 is displayed and working_state=1. working_state is sampled in the same cycle that seg is registered.
- Alarm blink:
  - While alarm_state=1, the blink counter counts 0..BLINK_DIV-1 and toggles the phase on wrap.
  - The first toggle, to OFF, happens BLINK_DIV cycles after alarm_state rises.
  - Phase OFF forces dig_sel=6'b111111 and seg=0. The scan keeps running underneath.
  - When alarm_state=0, the blink counter clears and the phase returns to ON on the next cycle.
- Simultaneous events:
  - Alarm off has priority over any digit output.
  - Scan wrap and converter LOAD in the same cycle: the new digit uses the new BCD on the following registered output.

Test Plan:
- Reset, then pill_count=0, bottle_count=0, SCAN_DIV=4 -> within 20 cycles bottle_bcd=0x000 and pill_bcd=0x000. Scan shows only index 0 and index 3 segments ('0'); the other digits are blank with dig_sel low in turn every 4 cycles.
- bottle_count=255, pill_count=9 -> bottle_bcd=0x255 and pill_bcd=0x009 within 20 cycles. Digits 5..3 show 2,5,5; digits 2..1 are blank; digit 0 shows 9.
- pill_count stepped 99->100 during SHIFT -> the first LOAD still gives 0x099; the next LOAD gives 0x100 with the tens digit shown as '0'.
- working_state=1 -> seg[7]=1 only on the dig_sel=6'b110111 cycles; working_state=0 -> seg[7] is never 1.
- alarm_state=1 with BLINK_DIV=16 -> display blanked (dig_sel=6'b111111) in alternating 16-cycle windows, with the first blank window starting 16 cycles after the rise. alarm_state=0 -> the display resumes within 2 cycles.
- rst_n pulsed low mid-SHIFT with bcd=0x123 displayed -> outputs go to reset values immediately. After release, the correct value reappears within 10 cycles.

Source files
------------

// File: rtl/pill_count_display.sv
// pill_count_display: converts the bottling controller's bottle and pill counts
// to BCD with a sequential double-dabble engine and scans them onto a 6-digit
// multiplexed 7-segment display with leading-zero blanking, a working-state
// decimal point and an alarm blink.
module pill_count_display #(
  parameter int unsigned SCAN_DIV  = 1000,
  parameter int unsigned BLINK_DIV = 250000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  bottle_count,
  input  logic [7:0]  pill_count,
  input  logic        working_state,
  input  logic        alarm_state,
  output logic [11:0] bottle_bcd,
  output logic [11:0] pill_bcd,
  output logic [7:0]  seg,
  output logic [5:0]  dig_sel
);

  localparam int unsigned SCAN_W  = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
  localparam int unsigned BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_LOAD
  } conv_state_t;

  conv_state_t r_state;
  conv_state_t w_state_nxt;

  logic [7:0]         r_bin_b;
  logic [7:0]         r_bin_p;
  logic [11:0]        r_acc_b;
  logic [11:0]        r_acc_p;
  logic [2:0]         r_shcnt;
  logic [11:0]        w_adj_b;
  logic [11:0]        w_adj_p;
  logic [19:0]        w_sh_b;
  logic [19:0]        w_sh_p;

  logic [SCAN_W-1:0]  r_scan_cnt;
  logic [2:0]         r_digit;
  logic [BLINK_W-1:0] r_blink_cnt;
  logic               r_blink_off;

  logic [3:0]         w_nib;
  logic               w_blank;
  logic [7:0]         w_seg_nxt;
  logic [5:0]         w_dig_nxt;

  // Add 3 to every BCD nibble that is 5 or more (double-dabble correction).
  function automatic logic [11:0] dd_adjust(input logic [11:0] a);
    logic [11:0] r;
    r = a;
    for (int unsigned i = 0; i < 3; i++) begin
      if (a[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = a[4*i +: 4] + 4'd3;
      end
    end
    return r;
  endfunction

  // Active-high segment pattern {g..a}; values above 9 show nothing.
  function automatic logic [6:0] seg7(input logic [3:0] n);
    logic [6:0] p;
    case (n)
      4'd0:    p = 7'h3F;
      4'd1:    p = 7'h06;
      4'd2:    p = 7'h5B;
      4'd3:    p = 7'h4F;
      4'd4:    p = 7'h66;
      4'd5:    p = 7'h6D;
      4'd6:    p = 7'h7D;
      4'd7:    p = 7'h07;
      4'd8:    p = 7'h7F;
      4'd9:    p = 7'h6F;
      default: p = 7'h00;
    endcase
    return p;
  endfunction

  // Converter state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Converter next state: IDLE -> 8 x SHIFT -> LOAD -> IDLE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  w_state_nxt = ST_SHIFT;
      ST_SHIFT: if (r_shcnt == 3'd7) w_state_nxt = ST_LOAD;
      ST_LOAD:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Correct then shift the {BCD, binary} pairs of both counts in parallel.
  always_comb begin
    w_adj_b = dd_adjust(r_acc_b);
    w_adj_p = dd_adjust(r_acc_p);
    w_sh_b  = {w_adj_b, r_bin_b} << 1;
    w_sh_p  = {w_adj_p, r_bin_p} << 1;
  end

  // Converter datapath: snapshot in IDLE, shift in SHIFT, publish in LOAD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bin_b    <= '0;
      r_bin_p    <= '0;
      r_acc_b    <= '0;
      r_acc_p    <= '0;
      r_shcnt    <= '0;
      bottle_bcd <= '0;
      pill_bcd   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_bin_b <= bottle_count;
          r_bin_p <= pill_count;
          r_acc_b <= '0;
          r_acc_p <= '0;
          r_shcnt <= '0;
        end
        ST_SHIFT: begin
          {r_acc_b, r_bin_b} <= w_sh_b;
          {r_acc_p, r_bin_p} <= w_sh_p;
          r_shcnt            <= r_shcnt + 3'd1;
        end
        ST_LOAD: begin
          bottle_bcd <= r_acc_b;
          pill_bcd   <= r_acc_p;
        end
        default: ;
      endcase
    end
  end

  // Scan divider and digit index 0..5.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scan_cnt <= '0;
      r_digit    <= '0;
    end else if (r_scan_cnt == SCAN_LAST) begin
      r_scan_cnt <= '0;
      r_digit    <= (r_digit == 3'd5) ? 3'd0 : r_digit + 3'd1;
    end else begin
      r_scan_cnt <= r_scan_cnt + 1'b1;
    end
  end

  // Alarm blink phase; cleared to ON as soon as the alarm drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_blink_cnt <= '0;
      r_blink_off <= 1'b0;
    end else if (!alarm_state) begin
      r_blink_cnt <= '0;
      r_blink_off <= 1'b0;
    end else if (r_blink_cnt == BLINK_LAST) begin
      r_blink_cnt <= '0;
      r_blink_off <= ~r_blink_off;
    end else begin
      r_blink_cnt <= r_blink_cnt + 1'b1;
    end
  end

  // Digit select, leading-zero blanking and segment pattern for the current index.
  always_comb begin
    w_nib   = 4'd0;
    w_blank = 1'b1;
    case (r_digit)
      3'd0: begin w_nib = pill_bcd[3:0];    w_blank = 1'b0; end
      3'd1: begin w_nib = pill_bcd[7:4];    w_blank = (pill_bcd[11:4] == 8'd0); end
      3'd2: begin w_nib = pill_bcd[11:8];   w_blank = (pill_bcd[11:8] == 4'd0); end
      3'd3: begin w_nib = bottle_bcd[3:0];  w_blank = 1'b0; end
      3'd4: begin w_nib = bottle_bcd[7:4];  w_blank = (bottle_bcd[11:4] == 8'd0); end
      3'd5: begin w_nib = bottle_bcd[11:8]; w_blank = (bottle_bcd[11:8] == 4'd0); end
      default: ;
    endcase
    w_seg_nxt = {(r_digit == 3'd3) && working_state, w_blank ? 7'h00 : seg7(w_nib)};
    w_dig_nxt = ~(6'b000001 << r_digit);
  end

  // Registered display outputs; blink OFF overrides any digit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg     <= '0;
      dig_sel <= '1;
    end else if (r_blink_off) begin
      seg     <= '0;
      dig_sel <= '1;
    end else begin
      seg     <= w_seg_nxt;
      dig_sel <= w_dig_nxt;
    end
  end

endmodule

// File: tb/tb_pill_count_display.sv
// Self-checking bench for pill_count_display: randomized and directed stimulus
// compared every cycle against a decimal-arithmetic model of the display.
module tb_pill_count_display;

  localparam int SD = 4;
  localparam int BD = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  bottle_count;
  logic [7:0]  pill_count;
  logic        working_state;
  logic        alarm_state;
  logic [11:0] bottle_bcd;
  logic [11:0] pill_bcd;
  logic [7:0]  seg;
  logic [5:0]  dig_sel;

  always #5 clk = ~clk;

  pill_count_display #(.SCAN_DIV(SD), .BLINK_DIV(BD)) dut (
    .clk(clk), .rst_n(rst_n), .bottle_count(bottle_count), .pill_count(pill_count),
    .working_state(working_state), .alarm_state(alarm_state),
    .bottle_bcd(bottle_bcd), .pill_bcd(pill_bcd), .seg(seg), .dig_sel(dig_sel)
  );

  int tests = 0;
  int fails = 0;

  // Model state: edges since reset release, conversion slot, snapshots,
  // published decimal values and consecutive alarm-high edges.
  int m_n, m_ph, m_snap_b, m_snap_p, m_bb, m_pb, m_run;
  logic [7:0]  exp_seg;
  logic [5:0]  exp_dig;

  function automatic logic [11:0] to_bcd(input int v);
    logic [3:0] h, t, o;
    h = 4'(v / 100);
    t = 4'((v / 10) % 10);
    o = 4'(v % 10);
    return {h, t, o};
  endfunction

  function automatic logic [6:0] pat(input int d);
    logic [6:0] tbl [10];
    tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    return tbl[d];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: actual=%0h expected=%0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_n = 0; m_ph = 0; m_snap_b = 0; m_snap_p = 0; m_bb = 0; m_pb = 0; m_run = 0;
    exp_seg = 8'h00; exp_dig = 6'h3F;
  endtask

  // Advance the model across one rising edge using the stable inputs.
  task automatic model_edge();
    int d, grp, pos, dv, p10;
    bit blank, off;
    if (!rst_n) begin
      model_reset();
      return;
    end
    d   = (m_n / SD) % 6;
    off = ((m_run / BD) % 2) == 1;
    if (off) begin
      exp_seg = 8'h00;
      exp_dig = 6'h3F;
    end else begin
      grp = (d < 3) ? m_pb : m_bb;
      pos = d % 3;
      p10 = (pos == 0) ? 1 : (pos == 1) ? 10 : 100;
      dv  = (grp / p10) % 10;
      blank = (pos == 2) ? (grp < 100) : (pos == 1) ? (grp < 10) : 1'b0;
      exp_seg = {(d == 3) && working_state, blank ? 7'h00 : pat(dv)};
      exp_dig = '1;
      exp_dig[d] = 1'b0;
    end
    if (m_ph == 0) begin
      m_snap_b = int'(bottle_count);
      m_snap_p = int'(pill_count);
    end
    if (m_ph == 9) begin
      m_bb = m_snap_b;
      m_pb = m_snap_p;
    end
    m_ph  = (m_ph + 1) % 10;
    m_n   = m_n + 1;
    m_run = alarm_state ? m_run + 1 : 0;
  endtask

  // One clock: model the edge, then compare all outputs just after it.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("bottle_bcd", 32'(bottle_bcd), 32'(to_bcd(m_bb)));
    chk("pill_bcd",   32'(pill_bcd),   32'(to_bcd(m_pb)));
    chk("seg",        32'(seg),        32'(exp_seg));
    chk("dig_sel",    32'(dig_sel),    32'(exp_dig));
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic align_ph(input int ph);
    for (int i = 0; i < 10 && m_ph != ph; i++) step();
    chk("align_timeout", 32'(m_ph), 32'(ph));
  endtask

  initial begin
    int lit_cnt, dp_cnt;
    rst_n = 1'b0; bottle_count = 8'd0; pill_count = 8'd0;
    working_state = 1'b0; alarm_state = 1'b0;
    model_reset();
    steps(2);
    chk("reset_seg", 32'(seg), 32'h00);
    chk("reset_dig", 32'(dig_sel), 32'h3F);
    rst_n = 1'b1;

    // All zero: only the ones digits light, each for SD cycles per 24-cycle frame.
    steps(20);
    chk("zero_bottle_lit", 32'(bottle_bcd), 32'h000);
    chk("zero_pill_lit",   32'(pill_bcd),   32'h000);
    lit_cnt = 0;
    for (int i = 0; i < 24; i++) begin
      step();
      if (seg != 8'h00) lit_cnt++;
      if (dig_sel == 6'b111110) chk("zero_d0_pat", 32'(seg), 32'h3F);
    end
    chk("zero_lit_cycles", 32'(lit_cnt), 32'd8);

    // 255 / 9: bottle digits 2,5,5; pill tens and hundreds blank.
    bottle_count = 8'd255; pill_count = 8'd9;
    steps(20);
    chk("b255_lit", 32'(bottle_bcd), 32'h255);
    chk("p9_lit",   32'(pill_bcd),   32'h009);
    lit_cnt = 0;
    for (int i = 0; i < 24; i++) begin
      step();
      if (seg != 8'h00) lit_cnt++;
      if (dig_sel == 6'b011111) chk("b_hund_pat", 32'(seg), 32'h5B);
      if (dig_sel == 6'b111110) chk("p_ones_pat", 32'(seg), 32'h6F);
    end
    chk("b255_lit_cycles", 32'(lit_cnt), 32'd16);

    // Input change during SHIFT is deferred to the next conversion.
    pill_count = 8'd99;
    steps(12);
    align_ph(3);
    pill_count = 8'd100;
    align_ph(0);
    chk("p99_first_load", 32'(pill_bcd), 32'h099);
    steps(10);
    chk("p100_next_load", 32'(pill_bcd), 32'h100);
    for (int i = 0; i < 24; i++) begin
      step();
      if (dig_sel == 6'b111101) chk("p100_tens_zero", 32'(seg), 32'h3F);
    end

    // Decimal point only on digit 3 while working.
    working_state = 1'b1;
    dp_cnt = 0;
    for (int i = 0; i < 24; i++) begin
      step();
      if (seg[7]) begin
        dp_cnt++;
        chk("dp_digit", 32'(dig_sel), 32'b110111);
      end
    end
    chk("dp_cycles", 32'(dp_cnt), 32'(SD));
    working_state = 1'b0;
    dp_cnt = 0;
    for (int i = 0; i < 24; i++) begin
      step();
      if (seg[7]) dp_cnt++;
    end
    chk("dp_off_cycles", 32'(dp_cnt), 32'd0);

    // Randomized counts and working flag.
    for (int i = 0; i < 300; i++) begin
      if ((i % 7) == 0) begin
        bottle_count  = 8'($urandom_range(0, 255));
        pill_count    = 8'($urandom_range(0, 255));
        working_state = 1'($urandom_range(0, 1));
      end
      step();
    end

    // Alarm blink with BD-cycle half periods.
    bottle_count = 8'd42; pill_count = 8'd7;
    steps(20);
    alarm_state = 1'b1;
    for (int j = 1; j <= 55; j++) begin
      step();
      if (j == 16) chk("blink_on_16",  32'(dig_sel == 6'h3F), 32'd0);
      if (j == 17) chk("blink_off_17", 32'(dig_sel == 6'h3F), 32'd1);
      if (j == 32) chk("blink_off_32", 32'(dig_sel == 6'h3F), 32'd1);
      if (j == 33) chk("blink_on_33",  32'(dig_sel == 6'h3F), 32'd0);
      if (j == 49) chk("blink_off_49", 32'(seg), 32'h00);
    end
    alarm_state = 1'b0;
    steps(2);
    chk("alarm_resume", 32'(dig_sel == 6'h3F), 32'd0);

    // Randomized alarm and inputs together.
    for (int i = 0; i < 400; i++) begin
      if ((i % 5) == 0) begin
        pill_count    = 8'($urandom);
        bottle_count  = 8'($urandom);
        working_state = 1'($urandom_range(0, 1));
      end
      if ((i % 23) == 0) alarm_state = 1'($urandom_range(0, 1));
      step();
    end
    alarm_state = 1'b0;

    // Asynchronous reset in the middle of a conversion.
    pill_count = 8'd123; bottle_count = 8'd200;
    steps(25);
    chk("p123_before_rst", 32'(pill_bcd), 32'h123);
    align_ph(4);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("async_rst_bbcd", 32'(bottle_bcd), 32'h000);
    chk("async_rst_pbcd", 32'(pill_bcd), 32'h000);
    chk("async_rst_seg",  32'(seg), 32'h00);
    chk("async_rst_dig",  32'(dig_sel), 32'h3F);
    steps(2);
    rst_n = 1'b1;
    steps(10);
    chk("p123_after_rst", 32'(pill_bcd), 32'h123);
    chk("b200_after_rst", 32'(bottle_bcd), 32'h200);
    steps(30);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
